// File: rtl/register_bank_ctrl.sv
// Sequencer for a bank of 2**AddrBits tri-state registers sharing one write bus and one read bus.
// Turns single read/write/clear/preset requests into glitch-free per-register strobes and returns one response.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// WRITE  | reg_ce on the target, waiting for a Tick edge to capture reg_d
// CLRPRE | single-cycle clear or preset pulse on the target
// RD_EN  | target enabled onto the shared read bus
// RD_CAP | bus settled, reg_q captured at the end of this cycle
// RESP   | response held until rsp_ready
module register_bank_ctrl #(
  parameter int NrOfBits = 8,
  parameter int AddrBits = 2,
  localparam int NrOfRegs = 2 ** AddrBits
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [AddrBits-1:0] req_addr,
  input  logic [NrOfBits-1:0] req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [NrOfBits-1:0] rsp_data,
  output logic [NrOfRegs-1:0] reg_cs,
  output logic [NrOfRegs-1:0] reg_ce,
  output logic [NrOfRegs-1:0] reg_rst,
  output logic [NrOfRegs-1:0] reg_pre,
  output logic [NrOfBits-1:0] reg_d,
  input  logic [NrOfBits-1:0] reg_q
);

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_PRESET = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    CLRPRE,
    RD_EN,
    RD_CAP,
    RESP
  } state_t;

  state_t                state_q;
  state_t                state_nxt;
  logic [1:0]            op_q;
  logic [1:0]            op_nxt;
  logic [AddrBits-1:0]   addr_q;
  logic [AddrBits-1:0]   addr_nxt;
  logic [NrOfRegs-1:0]   sel_nxt;
  logic                  handshake;

  assign req_ready = (state_q == IDLE) && !Reset;
  assign handshake = req_valid && req_ready;

  always_comb begin
    state_nxt = state_q;
    op_nxt    = handshake ? req_op : op_q;
    addr_nxt  = handshake ? req_addr : addr_q;
    sel_nxt   = NrOfRegs'(1) << addr_nxt;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          case (req_op)
            OP_READ:  state_nxt = RD_EN;
            OP_WRITE: state_nxt = WRITE;
            default:  state_nxt = CLRPRE;
          endcase
        end
      end
      WRITE:   if (Tick) state_nxt = RESP;
      CLRPRE:  state_nxt = RESP;
      RD_EN:   state_nxt = RD_CAP;
      RD_CAP:  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Register strobes are computed from the next state so each one is a plain flop output.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      op_q      <= OP_READ;
      addr_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      reg_cs    <= '1;
      reg_ce    <= '0;
      reg_rst   <= '0;
      reg_pre   <= '0;
      reg_d     <= '0;
    end else begin
      state_q   <= state_nxt;
      op_q      <= op_nxt;
      addr_q    <= addr_nxt;
      rsp_valid <= (state_nxt == RESP);
      if (handshake && (req_op == OP_WRITE)) begin
        reg_d <= req_wdata;
      end
      reg_ce  <= (state_nxt == WRITE) ? sel_nxt : '0;
      reg_rst <= ((state_nxt == CLRPRE) && (op_nxt == OP_CLEAR)) ? sel_nxt : '0;
      reg_pre <= ((state_nxt == CLRPRE) && (op_nxt == OP_PRESET)) ? sel_nxt : '0;
      reg_cs  <= ((state_nxt == RD_EN) || (state_nxt == RD_CAP)) ? ~sel_nxt : '1;
      if ((state_q != RESP) && (state_nxt == RESP)) begin
        case (state_q)
          WRITE:   rsp_data <= reg_d;
          CLRPRE:  rsp_data <= (op_q == OP_PRESET) ? '1 : '0;
          RD_CAP:  rsp_data <= reg_q;
          default: rsp_data <= rsp_data;
        endcase
      end
    end
  end

endmodule
